// File: rtl/vx_branch_resolve_if.sv
// Branch-resolution bundle: ALU branch_ctl inputs, scheduler response handshake and status.
interface vx_branch_resolve_if #(
    parameter int NUM_BLOCKS = 1,
    parameter int NUM_WARPS  = 4,
    parameter int PC_BITS    = 32
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [NUM_BLOCKS-1:0]         br_valid;
    logic [NUM_BLOCKS*NW_BITS-1:0] br_wid;
    logic [NUM_BLOCKS-1:0]         br_taken;
    logic [NUM_BLOCKS*PC_BITS-1:0] br_dest;
    logic                          stall_set;
    logic [NW_BITS-1:0]            stall_wid;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [NW_BITS-1:0]            rsp_wid;
    logic                          rsp_taken;
    logic [PC_BITS-1:0]            rsp_dest;
    logic [NUM_WARPS-1:0]          warp_stalled;
    logic                          overflow;

    modport master (
        output br_valid, br_wid, br_taken, br_dest, stall_set, stall_wid, rsp_ready,
        input  rsp_valid, rsp_wid, rsp_taken, rsp_dest, warp_stalled, overflow
    );

    modport slave (
        input  br_valid, br_wid, br_taken, br_dest, stall_set, stall_wid, rsp_ready,
        output rsp_valid, rsp_wid, rsp_taken, rsp_dest, warp_stalled, overflow
    );
endinterface

// File: rtl/vx_branch_resolve.sv
// Per-block branch resolution queues, round-robin delivery to the scheduler, warp stall bits.
// Optional BRANCH_RESOLVE_PERF_EN adds taken/not-taken handshake counters.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif
module vx_branch_resolve #(
    parameter int NUM_BLOCKS  = 1,
    parameter int NUM_WARPS   = 4,
    parameter int PC_BITS     = 32,
    parameter int QUEUE_DEPTH = 2
) (
    input logic clk,
    input logic reset,
    vx_branch_resolve_if.slave bus
`ifdef BRANCH_RESOLVE_PERF_EN
    ,
    output logic [`PERF_CTR_BITS-1:0] perf_taken,
    output logic [`PERF_CTR_BITS-1:0] perf_not_taken
`endif
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int AW      = $clog2(QUEUE_DEPTH);
    localparam int RR_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    logic [NW_BITS-1:0] q_wid   [NUM_BLOCKS][QUEUE_DEPTH];
    logic               q_taken [NUM_BLOCKS][QUEUE_DEPTH];
    logic [PC_BITS-1:0] q_dest  [NUM_BLOCKS][QUEUE_DEPTH];
    logic [AW:0]        wr_ptr  [NUM_BLOCKS];
    logic [AW:0]        rd_ptr  [NUM_BLOCKS];

    logic [NUM_BLOCKS-1:0] empty, full, pop, push;
    logic [RR_W-1:0]       rr_ptr, grant_idx;
    logic                  grant, out_free, fire;
    int                    idx;
    logic [NW_BITS-1:0]    head_wid;
    logic                  head_taken;
    logic [PC_BITS-1:0]    head_dest;

    logic                  rsp_valid_p1;
    logic [NW_BITS-1:0]    rsp_wid_p1;
    logic                  rsp_taken_p1;
    logic [PC_BITS-1:0]    rsp_dest_p1;
    logic [NUM_WARPS-1:0]  stalled_p1, stall_nxt;
    logic                  overflow_p1;

    assign out_free = !rsp_valid_p1 || bus.rsp_ready;
    assign fire     = rsp_valid_p1 && bus.rsp_ready;

    // Stage 0: queue status, round-robin search from the block after the last grant
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            empty[b] = (wr_ptr[b] == rd_ptr[b]);
            full[b]  = (wr_ptr[b][AW] != rd_ptr[b][AW]) &&
                       (wr_ptr[b][AW-1:0] == rd_ptr[b][AW-1:0]);
        end
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_BLOCKS;
            if (!grant && !empty[idx]) begin
                grant     = 1'b1;
                grant_idx = RR_W'(idx);
            end
        end
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            pop[b]  = out_free && grant && (grant_idx == RR_W'(b));
            // a full queue that is being popped this cycle still has room
            push[b] = bus.br_valid[b] && (!full[b] || pop[b]);
        end
    end

    always_comb begin
        head_wid   = q_wid[grant_idx][rd_ptr[grant_idx][AW-1:0]];
        head_taken = q_taken[grant_idx][rd_ptr[grant_idx][AW-1:0]];
        head_dest  = q_dest[grant_idx][rd_ptr[grant_idx][AW-1:0]];
    end

    always_comb begin
        stall_nxt = stalled_p1;
        if (fire)
            stall_nxt[rsp_wid_p1] = 1'b0;
        if (bus.stall_set)
            stall_nxt[bus.stall_wid] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (push[b]) begin
                q_wid[b][wr_ptr[b][AW-1:0]]   <= bus.br_wid[b*NW_BITS +: NW_BITS];
                q_taken[b][wr_ptr[b][AW-1:0]] <= bus.br_taken[b];
                q_dest[b][wr_ptr[b][AW-1:0]]  <= bus.br_dest[b*PC_BITS +: PC_BITS];
            end
        end
    end

    // Stage 1: pointers, arbitration state, registered response and status
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                wr_ptr[b] <= '0;
                rd_ptr[b] <= '0;
            end
            rr_ptr       <= '0;
            rsp_valid_p1 <= 1'b0;
            rsp_wid_p1   <= '0;
            rsp_taken_p1 <= 1'b0;
            rsp_dest_p1  <= '0;
            stalled_p1   <= '0;
            overflow_p1  <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                if (push[b])
                    wr_ptr[b] <= wr_ptr[b] + 1'b1;
                if (pop[b])
                    rd_ptr[b] <= rd_ptr[b] + 1'b1;
                if (bus.br_valid[b] && !push[b])
                    overflow_p1 <= 1'b1;
            end
            if (out_free) begin
                rsp_valid_p1 <= grant;
                if (grant) begin
                    rsp_wid_p1   <= head_wid;
                    rsp_taken_p1 <= head_taken;
                    rsp_dest_p1  <= head_dest;
                    rr_ptr       <= (grant_idx == RR_W'(NUM_BLOCKS - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            stalled_p1 <= stall_nxt;
        end
    end

`ifdef BRANCH_RESOLVE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_taken     <= '0;
            perf_not_taken <= '0;
        end else if (fire) begin
            if (rsp_taken_p1)
                perf_taken <= perf_taken + 1'b1;
            else
                perf_not_taken <= perf_not_taken + 1'b1;
        end
    end
`endif

    assign bus.rsp_valid    = rsp_valid_p1;
    assign bus.rsp_wid      = rsp_wid_p1;
    assign bus.rsp_taken    = rsp_taken_p1;
    assign bus.rsp_dest     = rsp_dest_p1;
    assign bus.warp_stalled = stalled_p1;
    assign bus.overflow     = overflow_p1;
endmodule

// File: tb/tb_vx_branch_resolve.sv
// Bench for vx_branch_resolve: directed vector table on a 1-block instance, hand sequences
// and a randomized queue-level reference model on a 2-block instance.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif
module tb_vx_branch_resolve;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic rst1, rst2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vx_branch_resolve_if #(.NUM_BLOCKS(1)) b1 ();
    vx_branch_resolve_if #(.NUM_BLOCKS(2)) b2 ();

`ifdef BRANCH_RESOLVE_PERF_EN
    logic [`PERF_CTR_BITS-1:0] pt1, pn1, pt2, pn2;
`endif

    vx_branch_resolve #(.NUM_BLOCKS(1), .QUEUE_DEPTH(QD)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1)
`ifdef BRANCH_RESOLVE_PERF_EN
        , .perf_taken(pt1), .perf_not_taken(pn1)
`endif
    );

    vx_branch_resolve #(.NUM_BLOCKS(2), .QUEUE_DEPTH(QD)) dut2 (
        .clk(clk), .reset(rst2), .bus(b2)
`ifdef BRANCH_RESOLVE_PERF_EN
        , .perf_taken(pt2), .perf_not_taken(pn2)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        logic [1:0]  wid;
        bit          tk;
        logic [31:0] dest;
        bit          rdy;
        bit          ss;
        logic [1:0]  sw;
        bit          e_vld;
        logic [1:0]  e_wid;
        bit          e_tk;
        logic [31:0] e_dest;
        logic [3:0]  e_st;
        bit          e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit v, logic [1:0] wid, bit tk, logic [31:0] dest,
                                bit rdy, bit ss, logic [1:0] sw, bit ev, logic [1:0] ew,
                                bit et, logic [31:0] ed, logic [3:0] est, bit eo);
        vec_t r;
        r.rst = rst; r.v = v; r.wid = wid; r.tk = tk; r.dest = dest; r.rdy = rdy;
        r.ss = ss; r.sw = sw; r.e_vld = ev; r.e_wid = ew; r.e_tk = et; r.e_dest = ed;
        r.e_st = est; r.e_ovf = eo;
        return r;
    endfunction

    task automatic step2(input bit v0, input logic [1:0] w0, input bit v1, input logic [1:0] w1);
        b2.br_valid  = {v1, v0};
        b2.br_wid    = {w1, w0};
        b2.br_taken  = 2'b00;
        b2.br_dest   = {30'h0, w1, 30'h0, w0};
        b2.rsp_ready = 1'b1;
        b2.stall_set = 1'b0;
        @(posedge clk); #1;
    endtask

    // model state for the 2-block instance
    logic [34:0] mq[2][$];
    bit          m_vld;
    logic [34:0] m_ent;
    int          m_rr;
    logic [3:0]  m_st;
    bit          m_ovf;
    longint      m_pt, m_pn;

    task automatic model_reset();
        mq[0].delete(); mq[1].delete();
        m_vld = 0; m_ent = '0; m_rr = 0; m_st = '0; m_ovf = 0; m_pt = 0; m_pn = 0;
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        b1.br_valid = '0; b1.br_wid = '0; b1.br_taken = '0; b1.br_dest = '0;
        b1.stall_set = 1'b0; b1.stall_wid = '0; b1.rsp_ready = 1'b0;
        b2.br_valid = '0; b2.br_wid = '0; b2.br_taken = '0; b2.br_dest = '0;
        b2.stall_set = 1'b0; b2.stall_wid = '0; b2.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", b1.rsp_valid, 0);
        chk("rst_wid", b1.rsp_wid, 0);
        chk("rst_taken", b1.rsp_taken, 0);
        chk("rst_dest", b1.rsp_dest, 0);
        chk("rst_stalled", b1.warp_stalled, 0);
        chk("rst_ovf", b1.overflow, 0);
        chk("rst2_vld", b2.rsp_valid, 0);
        rst1 = 1'b0; rst2 = 1'b0;

        //         rst v wid tk dest          rdy ss sw  ev ew et edest         st    ovf
        tbl.push_back(mk(0,1,2,1,32'h80000100,1,0,0, 0,0,0,32'h0,        4'h0,0));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,2,1,32'h80000100, 4'h0,0));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,32'h0,        4'h0,0));
        tbl.push_back(mk(0,1,1,0,32'h100,     0,0,0, 0,0,0,32'h0,        4'h0,0));
        tbl.push_back(mk(0,1,2,1,32'h200,     0,0,0, 1,1,0,32'h100,      4'h0,0));
        tbl.push_back(mk(0,1,3,0,32'h300,     0,0,0, 1,1,0,32'h100,      4'h0,0));
        tbl.push_back(mk(0,1,0,1,32'h400,     0,0,0, 1,1,0,32'h100,      4'h0,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,2,1,32'h200,      4'h0,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,3,0,32'h300,      4'h0,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,32'h0,        4'h0,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,32'h0,        4'h0,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,1,1, 0,0,0,32'h0,        4'h2,1));
        tbl.push_back(mk(0,1,1,1,32'h500,     1,0,0, 0,0,0,32'h0,        4'h2,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,1,1,32'h500,      4'h2,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,1,1, 0,0,0,32'h0,        4'h2,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,1,3, 0,0,0,32'h0,        4'hA,1));
        tbl.push_back(mk(0,1,1,0,32'h600,     1,0,0, 0,0,0,32'h0,        4'hA,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,1,0,32'h600,      4'hA,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,32'h0,        4'h8,1));
        tbl.push_back(mk(0,1,0,0,32'h700,     0,0,0, 0,0,0,32'h0,        4'h8,1));
        tbl.push_back(mk(0,1,1,0,32'h710,     0,0,0, 1,0,0,32'h700,      4'h8,1));
        tbl.push_back(mk(0,1,2,1,32'h720,     0,0,0, 1,0,0,32'h700,      4'h8,1));
        tbl.push_back(mk(0,1,3,0,32'h730,     1,0,0, 1,1,0,32'h710,      4'h8,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,2,1,32'h720,      4'h8,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,3,0,32'h730,      4'h8,1));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,32'h0,        4'h0,1));
        tbl.push_back(mk(0,1,1,0,32'h800,     0,0,0, 0,0,0,32'h0,        4'h0,1));
        tbl.push_back(mk(0,1,2,0,32'h810,     0,1,2, 1,1,0,32'h800,      4'h4,1));
        tbl.push_back(mk(0,1,3,0,32'h820,     0,0,0, 1,1,0,32'h800,      4'h4,1));
        tbl.push_back(mk(1,0,0,0,32'h0,       0,0,0, 0,0,0,32'h0,        4'h0,0));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,32'h0,        4'h0,0));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,32'h0,        4'h0,0));
        tbl.push_back(mk(0,1,0,0,32'h900,     0,0,0, 0,0,0,32'h0,        4'h0,0));
        tbl.push_back(mk(0,1,1,0,32'h910,     0,0,0, 1,0,0,32'h900,      4'h0,0));
        tbl.push_back(mk(0,1,2,0,32'h920,     0,0,0, 1,0,0,32'h900,      4'h0,0));
        tbl.push_back(mk(0,1,3,1,32'h930,     1,0,0, 1,1,0,32'h910,      4'h0,0));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,2,0,32'h920,      4'h0,0));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 1,3,1,32'h930,      4'h0,0));
        tbl.push_back(mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,32'h0,        4'h0,0));

        foreach (tbl[k]) begin
            rst1         = tbl[k].rst;
            b1.br_valid  = tbl[k].v;
            b1.br_wid    = tbl[k].wid;
            b1.br_taken  = tbl[k].tk;
            b1.br_dest   = tbl[k].dest;
            b1.rsp_ready = tbl[k].rdy;
            b1.stall_set = tbl[k].ss;
            b1.stall_wid = tbl[k].sw;
            @(posedge clk); #1;
            chk($sformatf("v%0d_vld", k), b1.rsp_valid, tbl[k].e_vld);
            if (tbl[k].e_vld) begin
                chk($sformatf("v%0d_wid", k), b1.rsp_wid, tbl[k].e_wid);
                chk($sformatf("v%0d_taken", k), b1.rsp_taken, tbl[k].e_tk);
                chk($sformatf("v%0d_dest", k), b1.rsp_dest, tbl[k].e_dest);
            end
            if (tbl[k].rst) begin
                chk($sformatf("v%0d_rst_wid", k), b1.rsp_wid, 0);
                chk($sformatf("v%0d_rst_dest", k), b1.rsp_dest, 0);
            end
            chk($sformatf("v%0d_stalled", k), b1.warp_stalled, tbl[k].e_st);
            chk($sformatf("v%0d_ovf", k), b1.overflow, tbl[k].e_ovf);
        end
        rst1 = 1'b0;
        b1.br_valid = '0; b1.stall_set = 1'b0;

        // two blocks in the same cycle, then rotation after a lone block-0 grant
        step2(1, 1, 1, 3); chk("rr_a_vld", b2.rsp_valid, 0);
        step2(0, 0, 0, 0); chk("rr_b_vld", b2.rsp_valid, 1); chk("rr_b_wid", b2.rsp_wid, 1);
        step2(0, 0, 0, 0); chk("rr_c_vld", b2.rsp_valid, 1); chk("rr_c_wid", b2.rsp_wid, 3);
        chk("rr_c_dest", b2.rsp_dest, 32'h3);
        step2(0, 0, 0, 0); chk("rr_d_vld", b2.rsp_valid, 0);
        step2(1, 0, 0, 0); chk("rr_e_vld", b2.rsp_valid, 0);
        step2(0, 0, 0, 0); chk("rr_f_wid", b2.rsp_wid, 0); chk("rr_f_vld", b2.rsp_valid, 1);
        step2(1, 1, 1, 3); chk("rr_g_vld", b2.rsp_valid, 0);
        step2(0, 0, 0, 0); chk("rr_h_vld", b2.rsp_valid, 1); chk("rr_h_wid", b2.rsp_wid, 3);
        step2(0, 0, 0, 0); chk("rr_i_vld", b2.rsp_valid, 1); chk("rr_i_wid", b2.rsp_wid, 1);
        step2(0, 0, 0, 0); chk("rr_j_vld", b2.rsp_valid, 0);

        // randomized run against the queue-level model
        rst2 = 1'b1;
        b2.br_valid = '0; b2.stall_set = 1'b0;
        @(posedge clk); #1;
        rst2 = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit          r, rdy, ss, hs, found;
            logic [1:0]  bv, sw;
            logic [3:0]  wids;
            logic [1:0]  tks;
            logic [63:0] dests;
            int          g;
            r     = ($urandom_range(0, 249) == 0);
            rdy   = ($urandom_range(0, 9) < 7);
            bv[0] = ($urandom_range(0, 9) < 4);
            bv[1] = ($urandom_range(0, 9) < 4);
            ss    = ($urandom_range(0, 9) < 3);
            sw    = 2'($urandom);
            wids  = 4'($urandom);
            tks   = 2'($urandom);
            dests = {32'($urandom), 32'($urandom)};
            rst2 = r;
            b2.br_valid = bv; b2.br_wid = wids; b2.br_taken = tks; b2.br_dest = dests;
            b2.rsp_ready = rdy; b2.stall_set = ss; b2.stall_wid = sw;

            if (r) begin
                model_reset();
            end else begin
                hs = m_vld && rdy;
                if (hs) begin
                    if (m_ent[32]) m_pt++; else m_pn++;
                    m_st[m_ent[34:33]] = 1'b0;
                end
                if (!m_vld || rdy) begin
                    found = 0; g = 0;
                    for (int i = 0; i < 2; i++)
                        if (!found && mq[(m_rr + i) % 2].size() > 0) begin
                            found = 1; g = (m_rr + i) % 2;
                        end
                    m_vld = found;
                    if (found) begin
                        m_ent = mq[g].pop_front();
                        m_rr  = (g + 1) % 2;
                    end
                end
                for (int b = 0; b < 2; b++)
                    if (bv[b]) begin
                        if (mq[b].size() < QD)
                            mq[b].push_back({wids[b*2 +: 2], tks[b], dests[b*32 +: 32]});
                        else
                            m_ovf = 1;
                    end
                if (ss) m_st[sw] = 1'b1;
            end

            @(posedge clk); #1;
            chk($sformatf("rnd%0d_vld", cyc), b2.rsp_valid, m_vld);
            if (m_vld) begin
                chk($sformatf("rnd%0d_wid", cyc), b2.rsp_wid, m_ent[34:33]);
                chk($sformatf("rnd%0d_taken", cyc), b2.rsp_taken, m_ent[32]);
                chk($sformatf("rnd%0d_dest", cyc), b2.rsp_dest, m_ent[31:0]);
            end
            chk($sformatf("rnd%0d_stalled", cyc), b2.warp_stalled, m_st);
            chk($sformatf("rnd%0d_ovf", cyc), b2.overflow, m_ovf);
`ifdef BRANCH_RESOLVE_PERF_EN
            chk($sformatf("rnd%0d_perf_taken", cyc), pt2, 64'(m_pt));
            chk($sformatf("rnd%0d_perf_not_taken", cyc), pn2, 64'(m_pn));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
